// File: rtl/cpu_step_pkg.sv
// Shared types and default timing constants for the CPU single-step controller.
package cpu_step_pkg;

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_PRESS  = 3'd1,
        S_STEP_C = 3'd2,
        S_STEP_I = 3'd3,
        S_RUN    = 3'd4,
        S_DRAIN  = 3'd5
    } state_e;

    // 12M cycles is roughly a quarter second at 48 MHz.
    localparam int CNT_W_DEF        = 24;
    localparam int LONG_CYCLES_DEF  = 12000000;
    localparam int STEP_TIMEOUT_DEF = 15;

endpackage

// File: rtl/press_timer.sv
// Saturating cycle counter with clear/enable; flags when the last count is reached.
module press_timer #(
    parameter int CNT_W = 24,
    parameter int LIMIT = 12000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic at_long_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Count up while enabled, holding at LIMIT-1 so the flag stays asserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign at_long_o = (cnt_q == LAST);

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns debounced push-button pulses into the 6502 RDY enable:
// short press steps a cycle or an instruction, long press free-runs,
// any press while running halts at the next opcode fetch.
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int LONG_CYCLES  = LONG_CYCLES_DEF,
    parameter int STEP_TIMEOUT = STEP_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_down,
    input  logic pb_up,
    input  logic pb_state,
    input  logic sync,
    input  logic step_instr,
    output logic cpu_rdy,
    output logic running,
    output logic step_done,
    output logic long_evt,
    output logic timeout_err
);

    state_e state_q, state_d;
    logic   first_q, first_d;
    logic   running_q, running_d;
    logic   step_done_q, step_done_d;
    logic   long_evt_q, long_evt_d;
    logic   timeout_q, timeout_d;
    logic   press_long;
    logic   step_expired;

    // Hold-time counter: restarts on every entry into PRESS.
    press_timer #(
        .CNT_W (CNT_W),
        .LIMIT (LONG_CYCLES)
    ) u_press_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q != S_PRESS),
        .en_i      (state_q == S_PRESS),
        .at_long_o (press_long)
    );

    // Instruction-step watchdog: restarts on every entry into STEP_I.
    press_timer #(
        .CNT_W (8),
        .LIMIT (STEP_TIMEOUT)
    ) u_step_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q != S_STEP_I),
        .en_i      (state_q == S_STEP_I),
        .at_long_o (step_expired)
    );

    // State and registered outputs; reset aborts any step or run silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_HALT;
            first_q     <= 1'b0;
            running_q   <= 1'b0;
            step_done_q <= 1'b0;
            long_evt_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            running_q   <= running_d;
            step_done_q <= step_done_d;
            long_evt_q  <= long_evt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state decode; presses in busy states are dropped, never queued.
    always_comb begin
        state_d     = state_q;
        first_d     = 1'b0;
        step_done_d = 1'b0;
        long_evt_d  = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            S_HALT: begin
                // pb_up here is the release of the press that stopped a run.
                if (pb_down) state_d = S_PRESS;
            end
            S_PRESS: begin
                // Release wins over a threshold reached in the same cycle.
                if (pb_up) begin
                    if (step_instr) begin
                        state_d = S_STEP_I;
                        first_d = 1'b1;
                    end else begin
                        state_d = S_STEP_C;
                    end
                end else if (press_long && pb_state) begin
                    state_d    = S_RUN;
                    long_evt_d = 1'b1;
                end
            end
            S_STEP_C: begin
                state_d     = S_HALT;
                step_done_d = 1'b1;
            end
            S_STEP_I: begin
                // The first cycle always runs: sync is still high from the parked fetch.
                if (!first_q) begin
                    if (sync) begin
                        state_d     = S_HALT;
                        step_done_d = 1'b1;
                    end else if (step_expired) begin
                        state_d     = S_HALT;
                        step_done_d = 1'b1;
                        timeout_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (pb_down) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (sync) begin
                    state_d     = S_HALT;
                    step_done_d = 1'b1;
                end
            end
            default: state_d = S_HALT;
        endcase
        running_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    // RDY must drop in the very cycle SYNC appears, so it is not registered.
    always_comb begin
        cpu_rdy = 1'b0;
        case (state_q)
            S_STEP_C: cpu_rdy = 1'b1;
            S_RUN:    cpu_rdy = 1'b1;
            S_STEP_I: cpu_rdy = first_q | ~sync;
            S_DRAIN:  cpu_rdy = ~sync;
            default:  cpu_rdy = 1'b0;
        endcase
    end

    assign running     = running_q;
    assign step_done   = step_done_q;
    assign long_evt    = long_evt_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with LONG_CYCLES=8, STEP_TIMEOUT=15.
module tb_cpu_step_ctrl;

    logic clk;
    logic rst_n;
    logic pb_down, pb_up, pb_state, sync, step_instr;
    logic cpu_rdy, running, step_done, long_evt, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_step_ctrl #(
        .CNT_W        (24),
        .LONG_CYCLES  (8),
        .STEP_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pb_down     (pb_down),
        .pb_up       (pb_up),
        .pb_state    (pb_state),
        .sync        (sync),
        .step_instr  (step_instr),
        .cpu_rdy     (cpu_rdy),
        .running     (running),
        .step_done   (step_done),
        .long_evt    (long_evt),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic rdy, input logic run,
                              input logic done, input logic lng, input logic to);
        check({tag, ".cpu_rdy"},     cpu_rdy,     rdy);
        check({tag, ".running"},     running,     run);
        check({tag, ".step_done"},   step_done,   done);
        check({tag, ".long_evt"},    long_evt,    lng);
        check({tag, ".timeout_err"}, timeout_err, to);
    endtask

    // Apply inputs just after a clock edge and let combinational RDY settle.
    task automatic drive(input logic d, input logic u, input logic s, input logic y);
        pb_down  = d;
        pb_up    = u;
        pb_state = s;
        sync     = y;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // pb_down, n-1 held cycles, then pb_up in the n-th cycle after pb_down.
    task automatic short_press(input string tag, input int n);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        expect_out({tag, ".down"}, 0, 0, 0, 0, 0);
        tick();
        for (int i = 1; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            expect_out({tag, ".hold"}, 0, 0, 0, 0, 0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out({tag, ".up"}, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        step_instr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        expect_out("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        expect_out("idle", 0, 0, 0, 0, 0);

        // Cycle step: RDY for one cycle right after release, then step_done.
        step_instr = 1'b0;
        short_press("cstep", 3);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("cstep.rdy", 1, 0, 0, 0, 0);
        tick();
        expect_out("cstep.done", 0, 0, 1, 0, 0);
        tick();
        expect_out("cstep.after", 0, 0, 0, 0, 0);

        // Instruction step: first cycle ignores sync, stops on the next sync.
        step_instr = 1'b1;
        short_press("istep", 3);
        step_instr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("istep.first", 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            expect_out("istep.mid", 1, 0, 0, 0, 0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        expect_out("istep.sync", 0, 0, 0, 0, 0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("istep.done", 0, 0, 1, 0, 0);
        tick();
        expect_out("istep.after", 0, 0, 0, 0, 0);

        // Long press: RUN begins 9 cycles after pb_down with one long_evt.
        for (int k = 0; k < 20; k++) begin
            drive(k == 0, 1'b0, 1'b1, 1'b0);
            expect_out("long.hold", k >= 9, k >= 9, 0, k == 9, 0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("long.release", 1, 1, 0, 0, 0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("run.after_release", 1, 1, 0, 0, 0);
        tick();

        // Stop press while running: drain until sync.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        expect_out("stop.down", 1, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            expect_out("drain.wait", 1, 1, 0, 0, 0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        expect_out("drain.sync", 0, 1, 0, 0, 0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("drain.done", 0, 0, 1, 0, 0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("halt.after_drain", 0, 0, 0, 0, 0);
        tick();

        // Release coinciding with the threshold count: short step, no run.
        step_instr = 1'b0;
        short_press("bound", 8);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("bound.step", 1, 0, 0, 0, 0);
        tick();
        expect_out("bound.done", 0, 0, 1, 0, 0);
        tick();
        expect_out("bound.after", 0, 0, 0, 0, 0);

        // Instruction step that never sees sync: aborted after 15 cycles.
        step_instr = 1'b1;
        short_press("tmo", 2);
        step_instr = 1'b0;
        for (int k = 0; k < 15; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            expect_out("tmo.run", 1, 0, 0, 0, 0);
            tick();
        end
        expect_out("tmo.abort", 0, 0, 1, 0, 1);
        tick();
        expect_out("tmo.after", 0, 0, 0, 0, 0);

        // Reset during RUN: immediate halt with no step_done.
        for (int k = 0; k < 12; k++) begin
            drive(k == 0, 1'b0, 1'b1, 1'b0);
            expect_out("rrun.hold", k >= 9, k >= 9, 0, k == 9, 0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_out("rrun.pre", 1, 1, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        #1;
        expect_out("rrun.reset", 0, 0, 0, 0, 0);
        tick();
        expect_out("rrun.nodone", 0, 0, 0, 0, 0);
        tick();
        short_press("rrun.step", 3);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("rrun.step.rdy", 1, 0, 0, 0, 0);
        tick();
        expect_out("rrun.step.done", 0, 0, 1, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
